// File: rtl/elastic_stage_reg.sv
// elastic_stage_reg: valid/ready pipeline stage with 2-entry skid buffer, flush-to-bubble and sticky halt
module elastic_stage_reg #(
    parameter int              DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter bit              HALT_EN    = 1'b1,
    parameter logic [DATA_W-1:0] HALT_VAL   = DATA_W'('h6F)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush,
    output logic [1:0]        o_count,
    output logic              o_halt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_main, r_skid;
    logic              r_halt;
    logic              w_in, w_out, w_load_main, w_skid_to_main, w_load_skid, w_halt_set;
    assign o_ready = (r_state != TWO) && !r_halt;
    assign o_valid = r_state != EMPTY;
    assign o_data  = o_valid ? r_main : BUBBLE_VAL;
    assign o_count = r_state;
    assign o_halt  = r_halt;
    assign w_in    = i_valid && o_ready;
    assign w_out   = o_valid && i_ready;
    // A flush discards same-cycle transfers, so a matching payload does not raise halt.
    assign w_halt_set = HALT_EN && w_in && !i_flush && (i_data == HALT_VAL);
    always_comb begin
        w_next         = r_state;
        w_load_main    = 1'b0;
        w_skid_to_main = 1'b0;
        w_load_skid    = 1'b0;
        case (r_state)
            EMPTY: begin
                w_next      = w_in ? ONE : EMPTY;
                w_load_main = w_in;
            end
            ONE: begin
                w_next      = (w_in && !w_out) ? TWO : (!w_in && w_out) ? EMPTY : ONE;
                w_load_main = w_in && w_out;
                w_load_skid = w_in && !w_out;
            end
            TWO: begin
                w_next         = w_out ? ONE : TWO;
                w_skid_to_main = w_out;
            end
            default: w_next = EMPTY;
        endcase
        if (i_flush)
            w_next = EMPTY;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_halt  <= 1'b0;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
        end else begin
            r_state <= w_next;
            if (w_load_main)
                r_main <= i_data;
            else if (w_skid_to_main)
                r_main <= r_skid;
            if (w_load_skid)
                r_skid <= i_data;
            if (w_halt_set)
                r_halt <= 1'b1;
        end
    end
endmodule

// File: tb/tb_elastic_stage_reg.sv
// tb_elastic_stage_reg: scoreboard bench for elastic_stage_reg
module tb_elastic_stage_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, i_ready = 1'b0, i_flush = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_ready, o_valid, o_halt;
    logic [31:0] o_data;
    logic [1:0]  o_count;
    logic [31:0] q[$];
    logic        m_halt = 1'b0;
    int          errs = 0, checks = 0;

    elastic_stage_reg dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .i_flush(i_flush),
        .o_count(o_count), .o_halt(o_halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic check_outs();
        chk("count", 32'(o_count), 32'(q.size()));
        chk("valid", 32'(o_valid), 32'(q.size() != 0));
        chk("data", o_data, q.size() != 0 ? q[0] : 32'h0);
        chk("ready", 32'(o_ready), 32'(q.size() < 2 && !m_halt));
        chk("halt", 32'(o_halt), 32'(m_halt));
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        logic in_x, out_x, rdy0;
        i_valid = v; i_data = d; i_flush = f; i_ready = !r;
        #1 rdy0 = o_ready;
        i_ready = r;
        #1 chk("ready_comb", 32'(o_ready), 32'(rdy0));
        check_outs();
        in_x  = v && q.size() < 2 && !m_halt;
        out_x = q.size() != 0 && r;
        if (f)
            q.delete();
        else begin
            if (out_x) void'(q.pop_front());
            if (in_x) begin
                q.push_back(d);
                if (d == 32'h6F) m_halt = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_halt = 1'b0;
        #1 check_outs();
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 5, 1'b0, 1'b0);
        step(1'b1, 6, 1'b0, 1'b0);
        step(1'b1, 7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 9, 1'b0, 1'b0);
        step(1'b1, 10, 1'b0, 1'b0);
        step(1'b1, 11, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 32'h6F, 1'b0, 1'b0);
        step(1'b1, 32'h13, 1'b1, 1'b0);
        step(1'b1, 32'h13, 1'b1, 1'b0);
        step(1'b1, 32'h13, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 32'h6F, 1'b1, 1'b1);
        do_reset();
        step(1'b1, 32'h6F, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 3, 1'b0, 1'b0);
        step(1'b1, 4, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 7, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (d == 32'h6F) d = 32'h70;
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
